mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  - Shares the single unified instruction/data memory port between two requesters:
//    - the fetch path (IF), which reads instructions;
//    - the load/store path (D), which reads and writes data.
//  - Sits between the control FSM/datapath and the memory macro, replacing the
//    hard-wired address mux and the tied-off write enable.
//  - Sequences each access: arbitrate -> issue -> wait for read latency -> return.
//  - Only one access is outstanding at any time.
// PARAMETERS
//  ADDR_W        32  address width, both requesters and the memory side
//  DATA_W        32  data width
//  MEM_LATENCY   1   cycles from mem_addr valid to mem_rdata valid; legal range 1..15
//  STARVE_LIMIT  4   max consecutive D grants while if_req is pending; legal range 1..15
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  if_req     in   1       fetch read request; held with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       one-cycle pulse: fetch request accepted
//  if_rvalid  out  1       one-cycle pulse: if_rdata is valid
//  if_rdata   out  DATA_W  fetched word; holds its value until the next fetch return
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata stable until d_gnt
//  d_we       in   1       1 = write, 0 = read
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       one-cycle pulse: data request accepted
//  d_rvalid   out  1       one-cycle pulse: read data valid, or write completed
//  d_rdata    out  DATA_W  load data; holds its value; not updated by writes
//  mem_addr   out  ADDR_W  registered address to memory (A)
//  mem_wdata  out  DATA_W  registered write data to memory (WD)
//  mem_we     out  1       registered write enable (WE); high for exactly one cycle per write
//  mem_rdata  in   DATA_W  memory read data (RD)
//  busy       out  1       1 while an access is outstanding (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs are 0, state = IDLE, latency counter = 0, starve counter = 0.
//  - FSM states:
//    - IDLE: on the edge where if_req|d_req is high, latch the winner into mem_*,
//      then go to WAIT.
//    - WAIT: count MEM_LATENCY cycles.
//    - RESP: return the result; next state is IDLE.
//  - Timing, with edge E0 as the arbitration edge:
//    - gnt is high during cycle [E0, E0+1).
//    - mem_addr is valid from E0.
//    - mem_we is high during [E0, E0+1) for writes only, and low at all other times.
//    - mem_rdata is captured at edge E0+MEM_LATENCY.
//    - rvalid is high during [E0+MEM_LATENCY, E0+MEM_LATENCY+1).
//    - The next arbitration edge is at E0+MEM_LATENCY+1.
//  - Throughput: one access per MEM_LATENCY+1 cycles.
//  - Requests seen in WAIT or RESP are ignored. The requester keeps req high until it
//    sees gnt. Because req is still high during the gnt cycle, it is not re-granted then.
//  - Priority (default):
//    - D wins over IF.
//    - The starve counter increments on each D grant made while if_req is high.
//    - It clears on any IF grant, and on any D grant made while if_req is low.
//    - When starve counter == STARVE_LIMIT and if_req is high, IF wins.
//  - Writes: d_rvalid pulses at the RESP cycle as a completion acknowledge; d_rdata is unchanged.
//  - mem_addr and mem_wdata hold their last values between accesses.
//  - Counters use saturating or wrap-free widths of 4 bits; no overflow is possible
//    within the legal ranges.
//  - Reset asserted mid-access:
//    - The access is abandoned and the FSM returns to IDLE.
//    - No rvalid is produced and mem_we is driven low immediately.
//  - Both requests on the same edge: exactly one gnt is produced. The loser is served
//    at the next arbitration edge if it still requests.
// CONFIGURATION
//  MEM_PORT_ARB_RR_EN
//  - Defined: round-robin arbitration.
//    - A last-winner flag (reset value = D, so IF wins the first contended edge)
//      gives priority to the other requester on contention.
//    - The starve counter and STARVE_LIMIT are unused.
//  - Undefined: fixed D priority with the STARVE_LIMIT escape described above.
// TESTING
//  1. Reset mid-WAIT:
//     - Stimulus: a read to 0x40 is outstanding; assert reset.
//     - Response: busy=0, mem_we=0 and both rvalids=0 immediately; after release,
//       the next if_req 0x0 is served normally.
//  2. Single fetch, MEM_LATENCY=1:
//     - Stimulus: if_req with if_addr=0x0000_0010 and mem returns 0x0050_0113.
//     - Response: if_gnt at cycle 1, if_rvalid at cycle 2, if_rdata=0x0050_0113,
//       mem_we=0 throughout.
//  3. Data write:
//     - Stimulus: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
//     - Response: mem_we high for exactly 1 cycle with mem_addr=0x100 and
//       mem_wdata=0xDEAD_BEEF; d_rvalid pulses once; d_rdata is unchanged.
//  4. Contention, default build, STARVE_LIMIT=4:
//     - Stimulus: if_req and d_req both held continuously.
//     - Response: the grant order is D,D,D,D,IF,D,D,D,D,IF.
//  5. Contention with MEM_PORT_ARB_RR_EN defined:
//     - Stimulus: the same stimulus as scenario 4.
//     - Response: the grant order is IF,D,IF,D,...
//  6. MEM_LATENCY=3, back-to-back loads:
//     - Stimulus: loads from 0x8 then 0xC.
//     - Response: d_rvalid 3 cycles after each d_gnt; the gnts are 4 cycles apart;
//       busy stays high except for the single IDLE edge between accesses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory port between fetch (IF) and load/store (D).
// Each access goes arbitrate -> issue -> wait out the read latency -> return, and only
// one access is ever outstanding.
// Build option: define MEM_PORT_ARB_RR_EN for round-robin arbitration. Otherwise D has
// fixed priority, and IF wins once D has been granted STARVE_LIMIT times in a row while
// if_req was waiting.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // WAIT plus RESP span MEM_LATENCY cycles, and RESP is always the final one.
  // mem_rdata is captured on the edge that leaves RESP, so the single IDLE cycle that
  // follows carries rvalid and is also the next arbitration cycle.
  localparam logic [3:0] LatLast = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              own_if_q, own_if_d;  // outstanding access belongs to IF
  logic              own_we_q, own_we_d;  // outstanding access is a write
  logic              pick_if, pick_d;

`ifdef MEM_PORT_ARB_RR_EN
  logic last_d_q, last_d_d;  // 1: D won the last grant
`else
  localparam logic [3:0] StarveLim = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
`endif

  // Winner selection among the current requests.
  always_comb begin
`ifdef MEM_PORT_ARB_RR_EN
    pick_if = if_req & (~d_req | last_d_q);
`else
    pick_if = if_req & (~d_req | (starve_q == StarveLim));
`endif
    pick_d = d_req & ~pick_if;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    own_if_d    = own_if_q;
    own_we_d    = own_we_q;
`ifdef MEM_PORT_ARB_RR_EN
    last_d_d    = last_d_q;
`else
    starve_d    = starve_q;
`endif
    case (state_q)
      StIdle: begin
        if (pick_if || pick_d) begin
          if_gnt_d   = pick_if;
          d_gnt_d    = pick_d;
          own_if_d   = pick_if;
          own_we_d   = pick_d & d_we;
          mem_we_d   = pick_d & d_we;
          mem_addr_d = pick_if ? if_addr : d_addr;
          // mem_wdata keeps the last store data; reads and fetches leave it alone.
          if (pick_d && d_we) mem_wdata_d = d_wdata;
          lat_cnt_d  = 4'd1;
          state_d    = (LatLast == 4'd0) ? StResp : StWait;
`ifdef MEM_PORT_ARB_RR_EN
          last_d_d   = pick_d;
`else
          if (pick_d && if_req) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
`endif
        end
      end
      StWait: begin
        if (lat_cnt_q >= LatLast) begin
          state_d = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      StResp: begin
        state_d   = StIdle;
        lat_cnt_d = 4'd0;
        if (own_if_q) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else begin
          d_rvalid_d = 1'b1;
          if (!own_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lat_cnt_q   <= 4'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      own_if_q    <= 1'b0;
      own_we_q    <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
      last_d_q    <= 1'b1;
`else
      starve_q    <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      own_if_q    <= own_if_d;
      own_we_q    <= own_we_d;
`ifdef MEM_PORT_ARB_RR_EN
      last_d_q    <= last_d_d;
`else
      starve_q    <= starve_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != StIdle);

endmodule
